// File: rtl/adc_to_bcd_voltage_if.sv
// ---------------------------------------------------------------------------
// adc_to_bcd_voltage_if
// Bundles the sample input and the BCD display-side outputs of
// adc_to_bcd_voltage.
//   sample / sample_valid          : ADC code and its qualifier (to the converter)
//   integer_data / float1_data /
//   float2_data                    : BCD digits X.YZ volts (from the converter)
//   data_valid                     : one-cycle pulse, digits updated
//   busy                           : conversion in progress
//   overrun                        : one-cycle pulse, a finished window was dropped
// master = sample producer / display consumer, slave = the converter.
// ---------------------------------------------------------------------------
interface adc_to_bcd_voltage_if #(
  parameter int ADC_WIDTH = 8
);
  logic [ADC_WIDTH-1:0] sample;
  logic                 sample_valid;
  logic [3:0]           integer_data;
  logic [3:0]           float1_data;
  logic [3:0]           float2_data;
  logic                 data_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output sample, sample_valid,
    input  integer_data, float1_data, float2_data, data_valid, busy, overrun
  );

  modport slave (
    input  sample, sample_valid,
    output integer_data, float1_data, float2_data, data_valid, busy, overrun
  );
endinterface

// File: rtl/adc_to_bcd_voltage.sv
// ---------------------------------------------------------------------------
// adc_to_bcd_voltage
// Averages 2^AVG_LOG2 ADC samples, scales the average to centivolts against
// VREF_CV with a sequential shift-add multiplier, and converts the result to
// three BCD digits with a sequential double-dabble.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : adc_to_bcd_voltage_if.slave (sample in, digits/status out)
// Latency: window-closing edge E0 -> digits and data_valid at E0+ADC_WIDTH+11.
// ---------------------------------------------------------------------------
module adc_to_bcd_voltage #(
  parameter int ADC_WIDTH = 8,
  parameter int AVG_LOG2  = 4,
  parameter int VREF_CV   = 330
) (
  input  logic                  clk,
  input  logic                  rst,
  adc_to_bcd_voltage_if.slave   bus
);

  localparam int SUM_W  = ADC_WIDTH + AVG_LOG2;
  localparam int PROD_W = ADC_WIDTH + 10;
  localparam int STEP_W = $clog2((ADC_WIDTH > 10) ? ADC_WIDTH : 10) + 1;

  // Reference must fit three BCD digits and be non-zero.
  if (VREF_CV < 1 || VREF_CV > 999) begin : g_vref_check
    $error("adc_to_bcd_voltage: VREF_CV must be within 1..999");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DAB, S_DONE} state_t;

  state_t                state_q;
  logic [AVG_LOG2-1:0]   count_q;
  logic [SUM_W-1:0]      sum_q;
  logic [ADC_WIDTH-1:0]  mplier_q;
  logic [PROD_W-1:0]     mcand_q;
  logic [PROD_W-1:0]     prod_q;
  logic [STEP_W-1:0]     step_q;
  logic [9:0]            bin_q;
  logic [11:0]           bcd_q;
  logic [3:0]            int_q, f1_q, f2_q;
  logic                  data_valid_q, busy_q, overrun_q;

  logic [SUM_W-1:0]      sum_d;
  logic [ADC_WIDTH-1:0]  avg_d;
  logic                  window_close;
  logic [PROD_W-1:0]     prod_d;
  logic [11:0]           bcd_adj;

  always_comb begin
    // Sum including the sample on this edge; the window's last sample must be
    // part of the average, so the average is taken from this value.
    sum_d        = sum_q + SUM_W'(bus.sample);
    avg_d        = ADC_WIDTH'(sum_d >> AVG_LOG2);
    window_close = bus.sample_valid && (count_q == '1);
    prod_d       = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dab_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                          : bcd_q[gi*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      sum_q        <= '0;
      mplier_q     <= '0;
      mcand_q      <= '0;
      prod_q       <= '0;
      step_q       <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      int_q        <= '0;
      f1_q         <= '0;
      f2_q         <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;

      // Accumulator runs regardless of the conversion FSM.
      if (bus.sample_valid) begin
        count_q <= count_q + AVG_LOG2'(1);
        sum_q   <= window_close ? '0 : sum_d;
      end

      // A window closing outside IDLE (including the DONE exit edge) is lost.
      if (window_close && state_q != S_IDLE) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (window_close) begin
            mplier_q <= avg_d;
            mcand_q  <= PROD_W'(VREF_CV);
            prod_q   <= '0;
            step_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          prod_q   <= prod_d;
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
          step_q   <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(ADC_WIDTH - 1)) begin
            // Final partial product is folded in here; keep only the
            // integer centivolt part (product / 2^ADC_WIDTH).
            bin_q   <= prod_d[PROD_W-1:ADC_WIDTH];
            bcd_q   <= '0;
            step_q  <= '0;
            state_q <= S_DAB;
          end
        end
        S_DAB: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          step_q         <= step_q + STEP_W'(1);
          if (step_q == STEP_W'(9)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          int_q        <= bcd_q[11:8];
          f1_q         <= bcd_q[7:4];
          f2_q         <= bcd_q[3:0];
          data_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.integer_data = int_q;
  assign bus.float1_data  = f1_q;
  assign bus.float2_data  = f2_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_to_bcd_voltage.sv
// ---------------------------------------------------------------------------
// tb_adc_to_bcd_voltage
// Two converters (VREF_CV 330 and 999) share clock, reset and samples. A
// cycle-stepped reference model predicts, after every rising edge, busy,
// data_valid, overrun and the three digits of each converter from the
// arithmetic definition (window average, scale, decimal digits) and the
// fixed conversion latency.
// ---------------------------------------------------------------------------
module tb_adc_to_bcd_voltage;

  localparam int AW  = 8;
  localparam int AL  = 4;
  localparam int WIN = 1 << AL;
  localparam int LAT = AW + 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_to_bcd_voltage_if #(.ADC_WIDTH(AW)) bus_a ();
  adc_to_bcd_voltage_if #(.ADC_WIDTH(AW)) bus_b ();

  adc_to_bcd_voltage #(.ADC_WIDTH(AW), .AVG_LOG2(AL), .VREF_CV(330)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  adc_to_bcd_voltage #(.ADC_WIDTH(AW), .AVG_LOG2(AL), .VREF_CV(999)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int vref [2] = '{330, 999};
  int m_sum, m_cnt, m_edge, m_done_edge;
  bit m_active, m_dv, m_ov;
  int m_pend [2][3];
  int m_dig  [2][3];

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_edge);
    end
  endtask

  // Next edge of the model: inputs r/v/s are what the DUTs see at that edge.
  task automatic model_edge(input bit r, input bit v, input int s);
    bit was_busy;
    int avg, cv;
    m_edge++;
    m_dv = 1'b0;
    m_ov = 1'b0;
    if (r) begin
      m_sum = 0; m_cnt = 0; m_active = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 3; k++) m_dig[d][k] = 0;
      return;
    end
    was_busy = m_active;
    if (m_active && m_edge == m_done_edge) begin
      m_dig    = m_pend;
      m_dv     = 1'b1;
      m_active = 1'b0;
    end
    if (v) begin
      m_sum += s;
      m_cnt++;
      if (m_cnt == WIN) begin
        avg   = m_sum / WIN;
        m_sum = 0;
        m_cnt = 0;
        if (was_busy) begin
          m_ov = 1'b1;
        end else begin
          m_active    = 1'b1;
          m_done_edge = m_edge + LAT;
          for (int d = 0; d < 2; d++) begin
            cv = (avg * vref[d]) / (1 << AW);
            m_pend[d][0] = cv / 100;
            m_pend[d][1] = (cv / 10) % 10;
            m_pend[d][2] = cv % 10;
          end
        end
      end
    end
  endtask

  task automatic compare_one(input int d, input logic b, input logic dv, input logic ov,
                             input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2);
    string p;
    p = (d == 0) ? "v330" : "v999";
    check_eq({p, ".busy"},       int'(b),  int'(m_active));
    check_eq({p, ".data_valid"}, int'(dv), int'(m_dv));
    check_eq({p, ".overrun"},    int'(ov), int'(m_ov));
    check_eq({p, ".integer"},    int'(i0), m_dig[d][0]);
    check_eq({p, ".float1"},     int'(i1), m_dig[d][1]);
    check_eq({p, ".float2"},     int'(i2), m_dig[d][2]);
  endtask

  task automatic step(input bit r, input bit v, input int s);
    logic [AW-1:0] code;
    code = s[AW-1:0];
    rst                = r;
    bus_a.sample_valid = v;
    bus_a.sample       = code;
    bus_b.sample_valid = v;
    bus_b.sample       = code;
    model_edge(r, v, int'(code));
    @(negedge clk);
    compare_one(0, bus_a.busy, bus_a.data_valid, bus_a.overrun,
                bus_a.integer_data, bus_a.float1_data, bus_a.float2_data);
    compare_one(1, bus_b.busy, bus_b.data_valid, bus_b.overrun,
                bus_b.integer_data, bus_b.float1_data, bus_b.float2_data);
    if (m_dv)
      $display("edge %0d: result %0d.%0d%0d V (330) / %0d.%0d%0d V (999)", m_edge,
               bus_a.integer_data, bus_a.float1_data, bus_a.float2_data,
               bus_b.integer_data, bus_b.float1_data, bus_b.float2_data);
    if (m_ov)
      $display("edge %0d: window dropped while busy", m_edge);
  endtask

  task automatic send(input int n, input int code, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, code);
      repeat (gap) step(1'b0, 1'b0, 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    m_sum = 0; m_cnt = 0; m_edge = 0; m_done_edge = 0;
    m_active = 1'b0; m_dv = 1'b0; m_ov = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin
        m_dig[d][k]  = 0;
        m_pend[d][k] = 0;
      end

    // Reset state
    repeat (3) step(1'b1, 1'b1, 200);

    // Full scale, sparse samples: 3.28 / 9.95
    send(WIN, 255, 3);
    idle(LAT + 4);

    // Zero, then mid-scale: 0.00 then 1.65
    send(WIN, 0, 1);
    idle(LAT + 2);
    send(WIN, 128, 0);
    idle(LAT + 2);

    // Truncation in the average and in the scaling: 1.28
    send(WIN / 2, 100, 0);
    send(WIN / 2, 101, 0);
    idle(LAT + 2);

    // Back-to-back windows: second one is dropped as overrun
    send(3 * WIN, 255, 0);
    idle(LAT + 2);

    // Reset in the middle of the double-dabble with a partial window pending
    send(WIN, 200, 0);
    send(5, 77, 0);
    idle(6);
    step(1'b1, 1'b0, 0);
    idle(2);
    send(WIN, 128, 0);
    idle(LAT + 2);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 2500; k++) begin
      step(($urandom_range(0, 699) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)));
    end
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_to_bcd_voltage.md
Name: adc_to_bcd_voltage

Overview:
- Upstream feeder for the 7-segment voltage display stage.
- Accepts raw ADC samples and averages them over a fixed window of 2^AVG_LOG2 samples.
- Scales the average to centivolts against VREF_CV.
- Converts the result to three BCD digits (X.YZ V) with a sequential shift-add multiplier followed by a sequential double-dabble.
- The digit outputs connect directly to the display's integer_data / float1_data / float2_data inputs.

Parameters:
- ADC_WIDTH, 8, width of the ADC sample code.
- AVG_LOG2, 4, log2 of samples per averaging window (window = 16).
- VREF_CV, 330, full-scale reference in centivolts. Must be between 1 and 999; elaboration fails otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sample  in  ADC_WIDTH  unsigned ADC code.
- sample_valid  in  1  sample is accepted on every rising clk edge where this is high.
- integer_data  out  4  BCD units-of-volts digit.
- float1_data  out  4  BCD tenths digit.
- float2_data  out  4  BCD hundredths digit.
- data_valid  out  1  one-cycle pulse; the three digits were updated on the same edge.
- busy  out  1  high while a conversion is in progress (MUL, DAB, DONE).
- overrun  out  1  one-cycle pulse; a completed window was discarded because busy was high.

Behaviour:
- Reset (rst=1 at an edge), regardless of state:
  - state=IDLE; sample count=0; sum=0.
  - All three digits=0; data_valid=0; busy=0; overrun=0.
  - Any conversion in flight is abandoned with no data_valid.
- Accumulator, independent of the FSM:
  - sum is ADC_WIDTH+AVG_LOG2 bits; count is AVG_LOG2 bits.
  - On each accepted sample: sum+=sample, count+=1.
  - The window closes at the edge where the 2^AVG_LOG2-th sample is accepted (count wraps to 0). sum and count clear on that edge; the next accepted sample starts a new window.
  - avg = (sum + closing sample) >> AVG_LOG2, truncated, ADC_WIDTH bits.
- Window close, state IDLE: avg is loaded as the multiplier operand; FSM goes to MUL; busy=1 from this edge.
- Window close, state not IDLE: avg is discarded, overrun pulses for one cycle, the running conversion is unaffected.
- FSM states:
  - IDLE: wait for window close.
  - MUL: shift-add of avg × VREF_CV, one multiplier bit per cycle, exactly ADC_WIDTH cycles. The product is ADC_WIDTH+10 bits. Then go to DAB.
  - DAB: value_cv = product >> ADC_WIDTH (truncated, 10 bits, always < VREF_CV ≤ 999). Run double-dabble for exactly 10 cycles: before each left shift, add 3 to every BCD nibble ≥ 5. Then go to DONE.
  - DONE: one cycle. At its exit edge, hundreds→integer_data, tens→float1_data, units→float2_data, data_valid=1 for the following cycle, busy=0, return to IDLE.
- Latency:
  - Edge E0 closes the window. Digits and data_valid change at edge E0+ADC_WIDTH+11 (19 for defaults).
  - busy is high for ADC_WIDTH+11 cycles.
- Digits hold their last value between updates; they never show intermediate values.
- A window closing on the same edge that DONE exits sees state≠IDLE and is counted as an overrun.
- sample_valid during rst is ignored.

Test Plan:
- 16 samples of code 255, one every 4 cycles → avg 255, 255×330>>8 = 328 → digits 3,2,8. data_valid is a single pulse 19 edges after the 16th sample. busy is high for 19 cycles.
- 16 samples of code 0 → digits 0,0,0 with data_valid pulse. Then 16 samples of code 128 → 128×330>>8 = 165 → digits 1,6,5.
- 8 samples of 100 then 8 of 101 → sum 1608, avg 100 (truncated), 33000>>8 = 128 → digits 1,2,8. Checks truncation at both stages.
- sample_valid=1 every cycle at code 255:
  - Window 1 closes at edge 16 → converts, result 3,2,8.
  - Window 2 closes at edge 32 while busy → overrun pulse, no extra data_valid.
  - Window 3 closes at edge 48 → converts normally.
- Assert rst for 1 cycle in the middle of DAB → all outputs 0 next cycle, no data_valid, count restarts. 16 further samples of 128 → 1,6,5.
- VREF_CV=999, ADC_WIDTH=8, 16 samples of 255 → 255×999>>8 = 995 → digits 9,9,5. Checks the largest BCD result and the 10-bit width.
